// File: rtl/ex_div.sv
// EX stage: single-cycle ALU plus a multi-cycle unsigned restoring divider (DIVU/REMU).
// state | meaning
// IDLE  | single-cycle ops pass through; a divide with nonzero divisor is latched here
// BUSY  | one restoring step per cycle, pipeline stalled
// DONE  | quotient or remainder presented with write enable for one cycle
module ex_div #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  id_aluop,
    input  logic [31:0] id_reg1,
    input  logic [31:0] id_reg2,
    input  logic [4:0]  id_wd,
    input  logic        id_wreg,
    input  logic        flush,
    output logic [4:0]  ex_wd,
    output logic        ex_wreg,
    output logic [31:0] ex_wdata,
    output logic        stallreq
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_REMU = 8'h1C;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt, cnt_nx;
    logic [31:0] dq, dq_nx;
    logic [31:0] divisor, divisor_nx;
    logic [31:0] rem, rem_nx;
    logic [4:0]  wd_q, wd_nx;
    logic        op_rem, op_rem_nx;

    logic [31:0] alu;
    logic        is_div;
    logic        div_start;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        alu = '0;
        case (id_aluop)
            OP_NOP:  alu = '0;
            OP_ADD:  alu = id_reg1 + id_reg2;
            OP_SUB:  alu = id_reg1 - id_reg2;
            OP_AND:  alu = id_reg1 & id_reg2;
            OP_OR:   alu = id_reg1 | id_reg2;
            OP_XOR:  alu = id_reg1 ^ id_reg2;
            OP_SLT:  alu = {31'd0, $signed(id_reg1) < $signed(id_reg2)};
            OP_SLTU: alu = {31'd0, id_reg1 < id_reg2};
            OP_SLL:  alu = id_reg1 << id_reg2[4:0];
            // divide-by-zero results; nonzero divisors go through the FSM
            OP_DIVU: alu = 32'hFFFF_FFFF;
            OP_REMU: alu = id_reg1;
            default: alu = '0;
        endcase
    end

    assign is_div    = (id_aluop == OP_DIVU) || (id_aluop == OP_REMU);
    assign div_start = is_div && (id_reg2 != 32'd0);

    // dq holds the remaining dividend bits in its upper part and collects quotient bits at the bottom
    assign rem_sh = {rem, dq[31]};
    assign diff   = rem_sh - {1'b0, divisor};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dq      <= '0;
            divisor <= '0;
            rem     <= '0;
            wd_q    <= '0;
            op_rem  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            dq      <= dq_nx;
            divisor <= divisor_nx;
            rem     <= rem_nx;
            wd_q    <= wd_nx;
            op_rem  <= op_rem_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        dq_nx      = dq;
        divisor_nx = divisor;
        rem_nx     = rem;
        wd_nx      = wd_q;
        op_rem_nx  = op_rem;
        ex_wd      = id_wd;
        ex_wreg    = id_wreg;
        ex_wdata   = alu;
        stallreq   = 1'b0;

        case (state)
            IDLE: begin
                if (div_start) begin
                    state_nx   = BUSY;
                    cnt_nx     = '0;
                    dq_nx      = id_reg1;
                    divisor_nx = id_reg2;
                    rem_nx     = '0;
                    wd_nx      = id_wd;
                    op_rem_nx  = (id_aluop == OP_REMU);
                    stallreq   = 1'b1;
                    ex_wreg    = 1'b0;
                    ex_wdata   = '0;
                end
            end
            BUSY: begin
                stallreq = 1'b1;
                ex_wreg  = 1'b0;
                ex_wd    = wd_q;
                ex_wdata = '0;
                dq_nx    = {dq[30:0], ~diff[32]};
                rem_nx   = diff[32] ? rem_sh[31:0] : diff[31:0];
                cnt_nx   = cnt + 6'd1;
                if (cnt == 6'(DIV_STEPS - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                ex_wd    = wd_q;
                ex_wreg  = 1'b1;
                ex_wdata = op_rem ? rem : dq;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            stallreq = 1'b0;
            ex_wreg  = 1'b0;
        end

        if (!rst) begin
            ex_wd    = '0;
            ex_wreg  = 1'b0;
            ex_wdata = '0;
            stallreq = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed cases plus random ops against an arithmetic reference.
module tb_ex_div;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_REMU = 8'h1C;
    localparam logic [7:0] OPS [14] = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                                        OP_SLTU, OP_SLL, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, 8'h55};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  id_aluop;
    logic [31:0] id_reg1;
    logic [31:0] id_reg2;
    logic [4:0]  id_wd;
    logic        id_wreg;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        stallreq;

    int checks = 0;
    int fails  = 0;

    ex_div #(.DIV_STEPS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .id_aluop (id_aluop),
        .id_reg1  (id_reg1),
        .id_reg2  (id_reg2),
        .id_wd    (id_wd),
        .id_wreg  (id_wreg),
        .flush    (flush),
        .ex_wd    (ex_wd),
        .ex_wreg  (ex_wreg),
        .ex_wdata (ex_wdata),
        .stallreq (stallreq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] prod;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            OP_SLTU: return {31'd0, a < b};
            OP_SLL: begin
                prod = {32'd0, a} * (64'd1 << b[4:0]);
                return prod[31:0];
            end
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_in(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wd, input logic wreg);
        @(posedge clk);
        #1;
        id_aluop = op;
        id_reg1  = a;
        id_reg2  = b;
        id_wd    = wd;
        id_wreg  = wreg;
        flush    = 1'b0;
    endtask

    task automatic single(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd, input logic wreg);
        step_in(op, a, b, wd, wreg);
        @(negedge clk);
        chk({tag, "_wdata"}, ex_wdata, ref_alu(op, a, b));
        chk({tag, "_wreg"}, {31'd0, ex_wreg}, {31'd0, wreg});
        chk({tag, "_wd"}, {27'd0, ex_wd}, {27'd0, wd});
        chk({tag, "_stall"}, {31'd0, stallreq}, 32'd0);
    endtask

    task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd);
        int n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        step_in(op, a, b, wd, 1'b1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stallreq) break;
            n++;
            if (ex_wreg) bad = 1'b1;
            @(posedge clk);
            #1;
            id_aluop = OP_ADD;
            id_reg1  = $urandom;
            id_reg2  = $urandom;
            id_wd    = 5'($urandom);
        end
        chk({tag, "_stall_len"}, 32'(n), 32'd33);
        chk({tag, "_busy_wreg"}, {31'd0, bad}, 32'd0);
        chk({tag, "_wdata"}, ex_wdata, (op == OP_DIVU) ? a / b : a % b);
        chk({tag, "_wreg"}, {31'd0, ex_wreg}, 32'd1);
        chk({tag, "_wd"}, {27'd0, ex_wd}, {27'd0, wd});
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a, b;

        rst      = 1'b0;
        id_aluop = OP_ADD;
        id_reg1  = 32'd1;
        id_reg2  = 32'd2;
        id_wd    = 5'd5;
        id_wreg  = 1'b1;
        flush    = 1'b0;
        #2;
        chk("rst_wdata", ex_wdata, 32'd0);
        chk("rst_wreg", {31'd0, ex_wreg}, 32'd0);
        chk("rst_wd", {27'd0, ex_wd}, 32'd0);
        chk("rst_stall", {31'd0, stallreq}, 32'd0);
        #20;
        rst = 1'b1;

        single("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
        single("slt", OP_SLT, 32'hFFFF_FFFF, 32'd0, 5'd1, 1'b1);
        single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd0, 5'd2, 1'b1);
        single("sll", OP_SLL, 32'h0000_00F1, 32'hFFFF_FFE4, 5'd4, 1'b0);
        single("undef", 8'h55, 32'h1234, 32'h5678, 5'd6, 1'b1);

        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd3);
        do_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd3);
        single("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 5'd8, 1'b1);
        single("remu_by0", OP_REMU, 32'h1234_5678, 32'd0, 5'd9, 1'b1);

        step_in(OP_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", {31'd0, stallreq}, 32'd0);
        chk("flush_idle_wreg", {31'd0, ex_wreg}, 32'd0);
        single("after_flush_idle", OP_OR, 32'hF0, 32'h0F, 5'd10, 1'b1);

        step_in(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd11, 1'b1);
        for (int k = 1; k < 10; k++) step_in(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("busy9_stall", {31'd0, stallreq}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_stall", {31'd0, stallreq}, 32'd0);
        chk("flush_busy_wreg", {31'd0, ex_wreg}, 32'd0);
        single("after_flush_busy", OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd12);

        for (int i = 0; i < 40; i++) begin
            op = OPS[$urandom_range(0, 13)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            if ((op == OP_DIVU || op == OP_REMU) && b != 32'd0)
                do_div("rnd_div", op, a, b, 5'($urandom));
            else
                single("rnd_alu", op, a, b, 5'($urandom), 1'($urandom));
        end

        step_in(OP_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
        for (int k = 1; k < 20; k++) step_in(OP_ADD, $urandom, $urandom, 5'd7, 1'b1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        id_aluop = OP_ADD;
        id_reg1  = 32'hAAAA_5555;
        id_reg2  = 32'h1;
        id_wd    = 5'd31;
        id_wreg  = 1'b1;
        #1;
        chk("midrst_wdata", ex_wdata, 32'd0);
        chk("midrst_wreg", {31'd0, ex_wreg}, 32'd0);
        chk("midrst_wd", {27'd0, ex_wd}, 32'd0);
        chk("midrst_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        single("sub_after_rst", OP_SUB, 32'd5, 32'd7, 5'd13, 1'b1);
        single("nop_after_rst", OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
